// File: rtl/access_arb_pkg.sv
// Shared types and constants for the access request arbiter.
// Optional lockout support is enabled with ACCESS_ARB_LOCKOUT_EN.
package access_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int LOCK_DENIES = 3;
  localparam int LOCK_CYCLES = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/access_req_arbiter_rr_picker.sv
// Combinational round-robin selector: first request at or after ptr.
// Shared by several arbiters; no state of its own.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // scan N positions starting at ptr, wrapping, first hit wins
  always_comb begin : pick
    int s;
    logic [IW-1:0] j;
    s     = 0;
    j     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      j = IW'(s);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/access_req_arbiter.sv
// Round-robin arbiter sharing one ID comparator among N_REQ requesters.
// Define ACCESS_ARB_LOCKOUT_EN to add repeated-deny lockout.
import access_arb_pkg::*;

module access_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ID_W-1:0]    req_id,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [idx_w(N_REQ)-1:0]  rsp_idx,
  output logic                     rsp_granted,
  output logic                     rsp_timeout,
  output logic [ID_W-1:0]          cmp_id_dynamic,
  output logic                     cmp_req_valid,
  input  logic                     cmp_granted,
  input  logic                     cmp_denied,
  output logic                     irq,
  output logic [CNT_W-1:0]         grant_cnt,
  output logic [CNT_W-1:0]         deny_cnt,
  output logic                     busy
`ifdef ACCESS_ARB_LOCKOUT_EN
  ,
  output logic [N_REQ-1:0]         lockout
`endif
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e       state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [IW-1:0]    win_q;
  logic [ID_W-1:0]  id_q;
  logic [15:0]      wcnt_q;
  logic [16:0]      wcnt_d;
  logic             cmp_req_q;
  logic             rsp_valid_q;
  logic [IW-1:0]    rsp_idx_q;
  logic             rsp_granted_q;
  logic             rsp_timeout_q;
  logic             irq_q;
  logic             busy_q;
  logic [CNT_W-1:0] grant_cnt_q;
  logic [CNT_W-1:0] deny_cnt_q;

  logic [N_REQ-1:0] req_m;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             hit;
  logic             grant_ok;
  logic             tmo;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign req_ready = (state_q == IDLE) ? pick_oh : '0;

  assign wcnt_d   = {1'b0, wcnt_q} + 17'd1;
  assign tmo      = (wcnt_d == 17'(TIMEOUT));
  assign hit      = cmp_granted | cmp_denied;
  // a simultaneous grant and deny resolves to deny
  assign grant_ok = cmp_granted & ~cmp_denied;
  assign ptr_d    = (win_q == IW'(N_REQ - 1))
                  ? '0 : win_q + IW'(1);

  // transaction FSM with registered comparator/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      id_q          <= '0;
      wcnt_q        <= '0;
      cmp_req_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_idx_q     <= '0;
      rsp_granted_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      irq_q         <= 1'b0;
      busy_q        <= 1'b0;
      grant_cnt_q   <= '0;
      deny_cnt_q    <= '0;
    end else begin
      cmp_req_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_idx_q     <= '0;
      rsp_granted_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      irq_q         <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            win_q     <= pick_idx;
            id_q      <= req_id[int'(pick_idx)*ID_W +: ID_W];
            cmp_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wcnt_q <= wcnt_d[15:0];
          if (hit || tmo) begin
            rsp_valid_q   <= 1'b1;
            rsp_idx_q     <= win_q;
            rsp_granted_q <= hit & grant_ok;
            rsp_timeout_q <= ~hit;
            irq_q         <= ~(hit & grant_ok);
            state_q       <= RESP;
            if (hit && grant_ok) begin
              if (~&grant_cnt_q)
                grant_cnt_q <= grant_cnt_q + CNT_W'(1);
            end else begin
              if (~&deny_cnt_q)
                deny_cnt_q <= deny_cnt_q + CNT_W'(1);
            end
          end
        end
        RESP: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ACCESS_ARB_LOCKOUT_EN
  localparam int LTW = $clog2(LOCK_CYCLES);

  logic [N_REQ-1:0] lock_q;
  logic [1:0]       dcnt_q [N_REQ];
  logic [LTW-1:0]   ltmr_q [N_REQ];

  // consecutive-deny tracking and timed lockout per requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        dcnt_q[i] <= '0;
        ltmr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (lock_q[i]) begin
          if (ltmr_q[i] == '0)
            lock_q[i] <= 1'b0;
          else
            ltmr_q[i] <= ltmr_q[i] - LTW'(1);
        end
        if (state_q == RESP && win_q == IW'(i)) begin
          if (rsp_granted_q) begin
            dcnt_q[i] <= '0;
          end else if (dcnt_q[i] == 2'(LOCK_DENIES - 1)) begin
            dcnt_q[i] <= '0;
            lock_q[i] <= 1'b1;
            ltmr_q[i] <= LTW'(LOCK_CYCLES - 1);
          end else begin
            dcnt_q[i] <= dcnt_q[i] + 2'd1;
          end
        end
      end
    end
  end

  assign req_m   = req_valid & ~lock_q;
  assign lockout = lock_q;
`else
  assign req_m = req_valid;
`endif

  assign cmp_req_valid  = cmp_req_q;
  assign cmp_id_dynamic = id_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_idx        = rsp_idx_q;
  assign rsp_granted    = rsp_granted_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign irq            = irq_q;
  assign grant_cnt      = grant_cnt_q;
  assign deny_cnt       = deny_cnt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_access_req_arbiter.sv
// Self-checking bench for access_req_arbiter against a behavioural model.
// Lockout scenario is exercised when ACCESS_ARB_LOCKOUT_EN is defined.
module tb_access_req_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 32;
  localparam int TO   = 8;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*IDW-1:0] req_id = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_idx;
  logic           rsp_granted;
  logic           rsp_timeout;
  logic [IDW-1:0] cmp_id_dynamic;
  logic           cmp_req_valid;
  logic           cmp_granted = 1'b0;
  logic           cmp_denied = 1'b0;
  logic           irq;
  logic [CW-1:0]  grant_cnt;
  logic [CW-1:0]  deny_cnt;
  logic           busy;
`ifdef ACCESS_ARB_LOCKOUT_EN
  logic [N-1:0]   lockout;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int ptr = 0;
  int eg = 0;
  int ed = 0;
  int streak [N];
  int lock_end [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  access_req_arbiter #(
    .N_REQ   (N),
    .ID_W    (IDW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_id         (req_id),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_idx        (rsp_idx),
    .rsp_granted    (rsp_granted),
    .rsp_timeout    (rsp_timeout),
    .cmp_id_dynamic (cmp_id_dynamic),
    .cmp_req_valid  (cmp_req_valid),
    .cmp_granted    (cmp_granted),
    .cmp_denied     (cmp_denied),
    .irq            (irq),
    .grant_cnt      (grant_cnt),
    .deny_cnt       (deny_cnt),
    .busy           (busy)
`ifdef ACCESS_ARB_LOCKOUT_EN
    ,
    .lockout        (lockout)
`endif
  );

  function automatic logic [N-1:0] lock_mask();
    logic [N-1:0] m;
    m = '0;
`ifdef ACCESS_ARB_LOCKOUT_EN
    for (int i = 0; i < N; i++)
      if (cyc <= lock_end[i]) m[i] = 1'b1;
`endif
    return m;
  endfunction

  function automatic int model_pick(input logic [N-1:0] m, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (m[2'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    ptr = 0;
    eg  = 0;
    ed  = 0;
    for (int i = 0; i < N; i++) begin
      streak[i]   = 0;
      lock_end[i] = -1;
    end
  endfunction

  function automatic void model_resp(input int w, input bit g);
    if (g) eg = (eg < CMAX) ? eg + 1 : CMAX;
    else   ed = (ed < CMAX) ? ed + 1 : CMAX;
`ifdef ACCESS_ARB_LOCKOUT_EN
    if (g) streak[w] = 0;
    else begin
      streak[w]++;
      if (streak[w] == 3) begin
        streak[w]   = 0;
        lock_end[w] = cyc + 1024;
      end
    end
`endif
    ptr = (w + 1) % N;
  endfunction

  // mode: 0 grant, 1 deny, 2 both, 3 silent, 4 stale pulse in ISSUE
  task automatic run_txn(input logic [N-1:0] mask, input int mode,
                         input int delay, input string tag,
                         output int got);
    logic [IDW-1:0] ids [N];
    logic [N-1:0] want_rdy;
    int w, k, lat;
    bit eg_b, et_b;
    got = -1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ids[i] = $urandom;
      req_id[i*IDW +: IDW] = ids[i];
    end
    req_valid = mask;
    w = model_pick(mask & ~lock_mask(), ptr);
    want_rdy = (w < 0) ? '0 : N'(1 << w);
    #1;
    nchk++;
    if (req_ready !== want_rdy) begin
      nerr++;
      $display("FAIL %s ready: got %b want %b", tag, req_ready, want_rdy);
    end
    if (w < 0) begin
      @(negedge clk);
      req_valid = '0;
      return;
    end
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (cmp_req_valid !== 1'b1 || cmp_id_dynamic !== ids[w] || busy !== 1'b1) begin
      nerr++;
      $display("FAIL %s issue: req=%b id=%h busy=%b want id=%h",
               tag, cmp_req_valid, cmp_id_dynamic, busy, ids[w]);
    end
    if (mode == 4) cmp_granted = 1'b1;
    k = 1;
    while (k < 20) begin
      @(negedge clk);
      k++;
      cmp_granted = 1'b0;
      cmp_denied  = 1'b0;
      if (rsp_valid) break;
      if (mode < 3 && k == 2 + delay) begin
        cmp_granted = (mode != 1);
        cmp_denied  = (mode != 0);
      end
    end
    eg_b = (mode == 0);
    et_b = (mode >= 3);
    lat  = et_b ? TO + 2 : 3 + delay;
    nchk++;
    if (k !== lat) begin
      nerr++;
      $display("FAIL %s latency: got %0d want %0d", tag, k, lat);
    end
    if (rsp_valid) begin
      got = int'(rsp_idx);
      model_resp(w, eg_b);
      nchk++;
      if (rsp_idx !== 2'(w) || rsp_granted !== eg_b ||
          rsp_timeout !== et_b || irq !== !eg_b) begin
        nerr++;
        $display("FAIL %s rsp: idx=%0d g=%b t=%b irq=%b want %0d %b %b %b",
                 tag, rsp_idx, rsp_granted, rsp_timeout, irq,
                 w, eg_b, et_b, !eg_b);
      end
      nchk++;
      if (grant_cnt !== CW'(eg) || deny_cnt !== CW'(ed)) begin
        nerr++;
        $display("FAIL %s counters: g=%0d d=%0d want %0d %0d",
                 tag, grant_cnt, deny_cnt, eg, ed);
      end
    end
    @(negedge clk);
    nchk++;
    if (rsp_valid !== 1'b0 || irq !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s after: rsp=%b irq=%b busy=%b want 0 0 0",
               tag, rsp_valid, irq, busy);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    nchk++;
    if ({req_ready, rsp_valid, rsp_idx, rsp_granted, rsp_timeout,
         cmp_id_dynamic, cmp_req_valid, irq, grant_cnt, deny_cnt,
         busy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b id=%h g=%0d d=%0d busy=%b want all 0",
               req_ready, rsp_valid, cmp_id_dynamic, grant_cnt, deny_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fairness();
    int got;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      run_txn(4'hF, 0, 0, "fair", got);
      nchk++;
      if (got !== order[i]) begin
        nerr++;
        $display("FAIL fair_order[%0d]: got %0d want %0d", i, got, order[i]);
      end
    end
  endtask

  task automatic test_single();
    int got;
    run_txn(4'b0001, 0, 0, "single", got);
  endtask

  task automatic test_timeout();
    int got;
    run_txn(4'b0100, 3, 0, "timeout", got);
  endtask

  task automatic test_results();
    int got;
    run_txn(4'b1000, 2, 3, "both", got);
    run_txn(4'b0010, 4, 0, "stale", got);
    run_txn(4'b0001, 1, 7, "late_deny", got);
    run_txn(4'b0100, 0, 7, "late_grant", got);
  endtask

  task automatic test_back_to_back();
    int got, last, w;
    bit pend;
    got  = 0;
    last = -1;
    pend = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      cmp_granted = pend;
      pend = cmp_req_valid;
      if (rsp_valid) begin
        w = model_pick(4'hF & ~lock_mask(), ptr);
        model_resp(w, 1'b1);
        nchk++;
        if (rsp_idx !== 2'(w) || rsp_granted !== 1'b1 ||
            grant_cnt !== CW'(eg)) begin
          nerr++;
          $display("FAIL b2b rsp: idx=%0d g=%b cnt=%0d want %0d 1 %0d",
                   rsp_idx, rsp_granted, grant_cnt, w, eg);
        end
        if (last >= 0) begin
          nchk++;
          if (c - last !== 4) begin
            nerr++;
            $display("FAIL b2b spacing: got %0d want 4", c - last);
          end
        end
        last = c;
        got++;
        if (got == 5) req_valid = '0;
      end
    end
    cmp_granted = 1'b0;
    nchk++;
    if (got !== 5) begin
      nerr++;
      $display("FAIL b2b count: got %0d want 5", got);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int got;
    for (int i = 0; i < 25; i++)
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 4),
              $urandom_range(0, 7), "rand", got);
  endtask

  task automatic test_reset_mid_wait();
    int got;
    bit seen;
    run_txn(4'b0010, 0, 0, "pre_rst", got);
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nchk++;
    if (busy !== 1'b0 || cmp_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid: busy=%b cmp=%b rsp=%b want 0 0 0",
               busy, cmp_req_valid, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || irq) seen = 1'b1;
    end
    nchk++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL rst_no_rsp: got %b want 0", seen);
    end
    nchk++;
    if (grant_cnt !== '0 || deny_cnt !== '0) begin
      nerr++;
      $display("FAIL rst_counters: g=%0d d=%0d want 0 0", grant_cnt, deny_cnt);
    end
    run_txn(4'hF, 0, 0, "post_rst", got);
    nchk++;
    if (got !== 0) begin
      nerr++;
      $display("FAIL rst_pointer: got %0d want 0", got);
    end
  endtask

`ifdef ACCESS_ARB_LOCKOUT_EN
  task automatic test_lockout();
    int got, n;
    for (int i = 0; i < 3; i++)
      run_txn(4'b0100, 1, 0, "lk_deny", got);
    nchk++;
    if (lockout !== lock_mask() || lockout[2] !== 1'b1) begin
      nerr++;
      $display("FAIL lk_set: got %b want %b", lockout, lock_mask());
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(4'b0110, 0, 0, "lk_mask", got);
      nchk++;
      if (got !== 1) begin
        nerr++;
        $display("FAIL lk_served: got %0d want 1", got);
      end
    end
    n = 0;
    while (cyc < lock_end[2] && n < 1200) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (lockout[2] !== 1'b1) begin
      nerr++;
      $display("FAIL lk_last: got %b want 1", lockout[2]);
    end
    @(negedge clk);
    nchk++;
    if (lockout[2] !== 1'b0) begin
      nerr++;
      $display("FAIL lk_clear: got %b want 0", lockout[2]);
    end
    run_txn(4'b0100, 0, 0, "lk_after", got);
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_timeout();
    test_results();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
`ifdef ACCESS_ARB_LOCKOUT_EN
    test_lockout();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/access_req_arbiter.md
Name: access_req_arbiter

Overview:
- Shares the single ID comparator (fixed-vs-dynamic ID check, grant/deny result) between N_REQ independent requesters.
- Round-robin selects one pending request and issues it to the comparator as a one-cycle request pulse with the requester's ID.
- Waits for a grant/deny result or a timeout, then returns a tagged response.
- Sits between requester-side logic (AXI register front-end, generator IP) and the comparator; also keeps grant/deny statistics and raises an interrupt on denial.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 32, ID width.
- TIMEOUT, 255, cycles to wait in WAIT before aborting (1..65535).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request pending.
- req_id  in  N_REQ*ID_W  per-requester ID; requester i uses slice [i*ID_W +: ID_W].
- req_ready  out  N_REQ  one-hot acceptance pulse.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_idx  out  $clog2(N_REQ)  requester the response belongs to.
- rsp_granted  out  1  1 = access granted.
- rsp_timeout  out  1  1 = comparator gave no result in time.
- cmp_id_dynamic  out  ID_W  ID presented to the comparator.
- cmp_req_valid  out  1  comparator request pulse.
- cmp_granted  in  1  comparator grant result.
- cmp_denied  in  1  comparator deny result.
- irq  out  1  one-cycle pulse on every deny or timeout response.
- grant_cnt  out  CNT_W  saturating count of granted responses.
- deny_cnt  out  CNT_W  saturating count of denied and timed-out responses.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset state:
  - FSM = IDLE; round-robin pointer = 0; cmp_id_dynamic = 0.
  - All outputs 0, including both counters.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid:
  - Winner = first set bit at or after the pointer, wrapping modulo N_REQ.
  - req_ready[winner] = 1 combinationally in that same cycle.
  - Capture winner index and its req_id; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready = 0.
- ISSUE (exactly one cycle):
  - cmp_req_valid = 1; cmp_id_dynamic = captured ID, held stable until the next capture.
  - Wait counter cleared; go to WAIT.
  - cmp_granted / cmp_denied arriving in this cycle are ignored; they are stale.
- WAIT:
  - Wait counter increments every cycle.
  - First cycle with cmp_granted or cmp_denied: latch the result and go to RESP.
  - Both asserted in the same cycle: result is deny (fail-safe).
  - Counter reaches TIMEOUT with no result: latch deny with timeout = 1, go to RESP.
- RESP (exactly one cycle):
  - rsp_valid = 1 with rsp_idx, rsp_granted, rsp_timeout. There is no backpressure; requesters must sample in that cycle.
  - Grant: grant_cnt += 1. Deny or timeout: deny_cnt += 1 and irq = 1. Counters saturate at all-ones.
  - Pointer = winner + 1, wrapping at N_REQ to 0. Go to IDLE.
- Latency:
  - Accept to rsp_valid = 3 cycles when the comparator answers in the first WAIT cycle.
  - Worst case = TIMEOUT + 2 cycles.
- Only one transaction is in flight. Requests arriving while busy are held by the requester, since req_valid is level; none is dropped.
- A requester that deasserts req_valid after acceptance still receives its response.
- rst asserted mid-transaction: immediate return to reset state; no rsp_valid and no irq for the aborted transaction.
- rsp_* outputs are registered and driven 0 outside RESP.

Optional Feature:
- Macro: ACCESS_ARB_LOCKOUT_EN.
- Defined:
  - Per-requester 2-bit consecutive-deny counter. Timeouts count as denies; a grant clears the counter.
  - On the 3rd consecutive deny the requester is locked out for 1024 cycles: masked from arbitration, its req_ready is never asserted, and its counter is cleared.
  - Extra output lockout [N_REQ] shows the locked requesters.
  - rst clears all lockouts.
- Not defined:
  - No masking; the lockout port is absent.

Decomposition:
- Package access_arb_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Lockout constants: LOCK_DENIES = 3, LOCK_CYCLES = 1024.
  - Function computing the index width from N_REQ.
- Sub-module rr_picker:
  - Combinational round-robin priority selector: request vector + pointer in, one-hot + index + any out.
  - Reused by other arbiters in the design.

Test Plan:
- Single request: req_valid = 0001, cmp_granted 1 cycle after cmp_req_valid → req_ready[0] pulse; cmp_id_dynamic = req_id[0]; rsp_valid 3 cycles after accept with idx = 0, granted = 1; grant_cnt = 1; irq = 0.
- Round-robin fairness: req_valid = 1111 held, comparator always grants → service order 0, 1, 2, 3, 0; no requester is served twice before the others are served once.
- Timeout: TIMEOUT = 8, comparator silent → rsp_valid exactly 10 cycles after accept with granted = 0, timeout = 1; irq pulses once; deny_cnt = 1.
- Simultaneous and stale results:
  - granted and denied asserted together in WAIT → granted = 0.
  - A result pulse during ISSUE only → ignored; the transaction times out.
- Reset mid-WAIT: assert rst for 1 cycle → busy = 0 immediately; no rsp_valid or irq follows; counters = 0; pointer = 0.
- With ACCESS_ARB_LOCKOUT_EN: requester 2 denied 3 times → lockout[2] = 1; its req_valid is ignored for 1024 cycles while requester 1 is still served; lockout[2] clears at cycle 1024.
